// File: rtl/freq_meas_sequencer.sv
// Wishbone master that runs one frequency-counter measurement per request:
// reset counter, wait ready, arm, poll done, read count/phase, clear, publish.
//
// state     | meaning
// IDLE      | waiting for start (or continuous re-run after DONE)
// RST_WR    | write 0x01 to the control register
// WAIT_RDY  | poll control register until ready (bit 5)
// ARM_WR    | write 0x80 to the control register, clear measurement timer
// POLL_DONE | poll control register until done (bit 6) or measurement timeout
// RD_COUNT  | read coarse count into shadow
// RD_PHASE  | read phase begin/end into shadow
// CLR_WR    | write 0x01 to the control register (also the abort/timeout exit)
// DONE      | result registers updated, valid pulse
// ERR       | bus idle, sticky error until next start
module freq_meas_sequencer #(
    parameter logic [31:0] ADDR_CTRL    = 32'h8,
    parameter logic [31:0] ADDR_COUNT   = 32'h9,
    parameter logic [31:0] ADDR_PHASE   = 32'hA,
    parameter int unsigned POLL_GAP     = 16,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter logic [31:0] MEAS_TIMEOUT = 32'd50_000_000
) (
    input  logic        clk_i,
    input  logic        ext_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        continuous_i,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic [31:0] result_count_o,
    output logic [3:0]  result_phase_begin_o,
    output logic [3:0]  result_phase_end_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic        error_o,
    output logic [1:0]  error_code_o,
    output logic [3:0]  state_o
);
    localparam int unsigned ACW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GW  = $clog2(POLL_GAP + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_RST_WR    = 4'd1;
    localparam logic [3:0] S_WAIT_RDY  = 4'd2;
    localparam logic [3:0] S_ARM_WR    = 4'd3;
    localparam logic [3:0] S_POLL_DONE = 4'd4;
    localparam logic [3:0] S_RD_COUNT  = 4'd5;
    localparam logic [3:0] S_RD_PHASE  = 4'd6;
    localparam logic [3:0] S_CLR_WR    = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERR       = 4'd9;

    logic [3:0]     r_state;
    logic           r_stb, r_first, r_we;
    logic [ACW-1:0] r_ack_cnt;
    logic [GW-1:0]  r_gap;
    logic [31:0]    r_adr, r_dat, r_timer;
    logic           r_tflag, r_abort, r_from_done;
    logic [31:0]    r_sh_count, r_res_count;
    logic [7:0]     r_sh_phase, r_res_phase;
    logic           r_valid, r_error;
    logic [1:0]     r_code;

    logic           w_busy, w_we, w_abort_req, w_poll_miss;
    logic [31:0]    w_adr, w_wdat;
    logic [3:0]     w_ack_nxt;

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_ERR);
    assign w_abort_req = abort_i | r_abort;

    always_comb begin
        w_we   = 1'b0;
        w_adr  = ADDR_CTRL;
        w_wdat = 32'h01;
        case (r_state)
            S_RST_WR, S_CLR_WR: w_we = 1'b1;
            S_ARM_WR: begin
                w_we   = 1'b1;
                w_wdat = 32'h80;
            end
            S_RD_COUNT: w_adr = ADDR_COUNT;
            S_RD_PHASE: w_adr = ADDR_PHASE;
            default: ;
        endcase
    end

    // Successor state when the current access is acknowledged.
    always_comb begin
        w_ack_nxt   = r_state;
        w_poll_miss = 1'b0;
        case (r_state)
            S_RST_WR:    w_ack_nxt = S_WAIT_RDY;
            S_WAIT_RDY:  if (m_dat_i[5]) w_ack_nxt = S_ARM_WR; else w_poll_miss = 1'b1;
            S_ARM_WR:    w_ack_nxt = S_POLL_DONE;
            S_POLL_DONE: if (m_dat_i[6]) w_ack_nxt = S_RD_COUNT; else w_poll_miss = 1'b1;
            S_RD_COUNT:  w_ack_nxt = S_RD_PHASE;
            S_RD_PHASE:  w_ack_nxt = S_CLR_WR;
            S_CLR_WR:    w_ack_nxt = r_tflag ? S_ERR : (w_abort_req ? S_IDLE : S_DONE);
            default: ;
        endcase
        if (w_abort_req && r_state != S_CLR_WR)
            w_ack_nxt = S_CLR_WR;
    end

    always_ff @(posedge clk_i or negedge ext_rst_i) begin
        if (!ext_rst_i) begin
            r_state     <= S_IDLE;
            r_stb       <= 1'b0;
            r_first     <= 1'b0;
            r_we        <= 1'b0;
            r_ack_cnt   <= '0;
            r_gap       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_timer     <= '0;
            r_tflag     <= 1'b0;
            r_abort     <= 1'b0;
            r_from_done <= 1'b0;
            r_sh_count  <= '0;
            r_sh_phase  <= '0;
            r_res_count <= '0;
            r_res_phase <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_code      <= 2'd0;
        end else begin
            r_valid <= 1'b0;
            if (abort_i && w_busy)
                r_abort <= 1'b1;
            if (r_state == S_POLL_DONE && r_timer != MEAS_TIMEOUT)
                r_timer <= r_timer + 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (start_i || (continuous_i && r_from_done)) begin
                        r_state     <= S_RST_WR;
                        r_from_done <= 1'b0;
                        r_gap       <= '0;
                        r_tflag     <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (start_i) begin
                        r_state <= S_RST_WR;
                        r_error <= 1'b0;
                        r_code  <= 2'd0;
                        r_gap   <= '0;
                        r_tflag <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_abort <= 1'b0;
                    if (w_abort_req)
                        r_state <= S_IDLE;
                    else if (continuous_i)
                        r_state <= S_RST_WR;
                    else begin
                        r_state     <= S_IDLE;
                        r_from_done <= 1'b1;
                    end
                end
                default: begin
                    if (r_stb) begin
                        // First strobe cycle may carry a stale ack from the slave.
                        if (r_first)
                            r_first <= 1'b0;
                        else if (m_err_i) begin
                            r_stb   <= 1'b0;
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_code  <= 2'd1;
                            r_abort <= 1'b0;
                        end else if (m_ack_i) begin
                            r_stb   <= 1'b0;
                            r_state <= w_ack_nxt;
                            r_gap   <= (w_poll_miss && !w_abort_req) ? GW'(POLL_GAP - 1) : '0;
                            if (r_state == S_ARM_WR)
                                r_timer <= '0;
                            if (r_state == S_RD_COUNT)
                                r_sh_count <= m_dat_i;
                            if (r_state == S_RD_PHASE)
                                r_sh_phase <= m_dat_i[7:0];
                            if (w_ack_nxt == S_ERR) begin
                                r_error <= 1'b1;
                                r_code  <= 2'd3;
                                r_abort <= 1'b0;
                            end
                            if (w_ack_nxt == S_IDLE)
                                r_abort <= 1'b0;
                            if (w_ack_nxt == S_DONE) begin
                                r_res_count <= r_sh_count;
                                r_res_phase <= r_sh_phase;
                                r_valid     <= 1'b1;
                            end
                        end else if (r_ack_cnt == ACW'(ACK_TIMEOUT - 1)) begin
                            r_stb   <= 1'b0;
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_code  <= 2'd2;
                            r_abort <= 1'b0;
                        end else
                            r_ack_cnt <= r_ack_cnt + 1'b1;
                    end else if (w_abort_req && r_state != S_CLR_WR)
                        r_state <= S_CLR_WR;
                    else if (r_state == S_POLL_DONE && r_timer == MEAS_TIMEOUT) begin
                        r_state <= S_CLR_WR;
                        r_tflag <= 1'b1;
                    end else if (r_gap != '0)
                        r_gap <= r_gap - 1'b1;
                    else begin
                        r_stb     <= 1'b1;
                        r_first   <= 1'b1;
                        r_ack_cnt <= '0;
                        r_adr     <= w_adr;
                        r_we      <= w_we;
                        r_dat     <= w_we ? w_wdat : 32'd0;
                    end
                end
            endcase
        end
    end

    assign m_adr_o              = r_adr;
    assign m_dat_o              = r_dat;
    assign m_we_o               = r_we;
    assign m_sel_o              = r_stb ? 4'hF : 4'h0;
    assign m_cyc_o              = r_stb;
    assign m_stb_o              = r_stb;
    assign result_count_o       = r_res_count;
    assign result_phase_begin_o = r_res_phase[3:0];
    assign result_phase_end_o   = r_res_phase[7:4];
    assign result_valid_o       = r_valid;
    assign busy_o               = w_busy;
    assign error_o              = r_error;
    assign error_code_o         = r_code;
    assign state_o              = r_state;
endmodule
